comparator: RTL and testbench

- Streaming 32-bit word comparator for the Ethernet sniffer datapath.
- Each clock it compares the incoming word against up to 8 parameter-programmed masked patterns.
- It flags single-word hits and a two-word sequence hit (pattern 0 followed by pattern 1), and keeps a saturating hit counter.
- All results are packed into one registered 32-bit status word consumed by the downstream result/address logic.

---
 rtl/comparator.sv | 55 +++++
 tb/tb_comparator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/comparator.sv
// Streaming 32-bit masked pattern comparator: per-slot hits, first-hit index,
// pattern0->pattern1 sequence detect and a saturating hit counter, packed into one status word.
module comparator #(
  parameter int                    NUM_PAT  = 8,
  parameter logic [32*NUM_PAT-1:0] PATTERNS = '0,
  parameter logic [32*NUM_PAT-1:0] MASKS    = {NUM_PAT{32'hFFFF_FFFF}},
  parameter logic [NUM_PAT-1:0]    PAT_EN   = '0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  logic [NUM_PAT-1:0] m;
  logic [2:0]         first_idx;
  logic               any_hit;
  logic               seq_hit;
  logic               prev_m0;
  logic [15:0]        hit_cnt;
  logic [15:0]        hit_cnt_next;

  // The counter lives in the status register itself; no separate copy is kept.
  assign hit_cnt = data_out[31:16];

  // NOTE: every combinational output gets a default before the loops so no latch is inferred.
  always_comb begin
    m         = '0;
    first_idx = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      m[i] = PAT_EN[i] &&
             ((data_in & MASKS[32*i +: 32]) == (PATTERNS[32*i +: 32] & MASKS[32*i +: 32]));
    end
    // Scan downward so the lowest set slot is the last to write the index.
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (m[i]) first_idx = 3'(i);
    end
  end

  assign any_hit      = |m;
  assign seq_hit      = prev_m0 && m[1];
  assign hit_cnt_next = (any_hit && (hit_cnt != 16'hFFFF)) ? hit_cnt + 16'd1 : hit_cnt;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      data_out <= '0;
      prev_m0  <= 1'b0;
    end else begin
      data_out <= {hit_cnt_next, 3'b000, seq_hit, any_hit, first_idx, m[7:0]};
      prev_m0  <= m[0];
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench: three comparator configurations share one stream; a behavioural
// model predicts each status word and a monitor compares one cycle later.
module tb_comparator;

  localparam logic [255:0] A_PAT = {32'hDEAD_BEEF, 32'h0, 32'h0000_5678, 32'h0,
                                    32'h1234_0000, 32'h0800_4500, 32'h5555_0000, 32'hAAAA_0000};
  localparam logic [255:0] A_MSK = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF,
                                    32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [7:0]   A_EN  = 8'hAF;
  localparam logic [255:0] S_PAT = {192'h0, 32'h5555_0000, 32'h0};
  localparam logic [255:0] S_MSK = {{6{32'hFFFF_FFFF}}, 32'hFFFF_FFFF, 32'h0};
  localparam logic [7:0]   S_EN  = 8'h03;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [31:0] data_in = 32'h0;
  logic [31:0] def_data = 32'h0;
  logic [31:0] out_def, out_a, out_sat;

  always #5 clk = ~clk;

  comparator u_def (.clk(clk), .n_rst(n_rst), .data_in(def_data), .data_out(out_def));
  comparator #(.PATTERNS(A_PAT), .MASKS(A_MSK), .PAT_EN(A_EN))
    u_a (.clk(clk), .n_rst(n_rst), .data_in(data_in), .data_out(out_a));
  comparator #(.PATTERNS(S_PAT), .MASKS(S_MSK), .PAT_EN(S_EN))
    u_sat (.clk(clk), .n_rst(n_rst), .data_in(data_in), .data_out(out_sat));

  typedef struct {
    int          edge_no;
    logic [31:0] e_def;
    logic [31:0] e_a;
    logic [31:0] e_sat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;

  logic [255:0] cfg_pat [3];
  logic [255:0] cfg_msk [3];
  logic [7:0]   cfg_en  [3];
  bit           prev0   [3];
  int           cnt     [3];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: hits are counted as plain integers, clamped at the 16-bit ceiling.
  function automatic logic [31:0] model(input int d, input logic [31:0] w);
    logic [7:0] hits = '0;
    int         idx = 0;
    bit         seq;
    for (int i = 0; i < 8; i++)
      if (cfg_en[d][i] && ((w & cfg_msk[d][32*i +: 32]) == (cfg_pat[d][32*i +: 32] & cfg_msk[d][32*i +: 32])))
        hits[i] = 1'b1;
    for (int i = 7; i >= 0; i--) if (hits[i]) idx = i;
    seq = prev0[d] && hits[1];
    if (hits != 0) cnt[d] = (cnt[d] >= 65535) ? 65535 : cnt[d] + 1;
    prev0[d] = hits[0];
    return {16'(cnt[d]), 3'b000, seq, (hits != 0), 3'(idx), hits};
  endfunction

  task automatic step(input logic [31:0] w, input bit rst, input bit x_def = 1'b0);
    exp_t e;
    @(posedge clk);
    #2;
    n_rst    = rst;
    data_in  = w;
    def_data = x_def ? 32'hx : w;
    e.edge_no = edge_cnt + 1;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin prev0[d] = 0; cnt[d] = 0; end
      e.e_def = '0; e.e_a = '0; e.e_sat = '0;
    end else begin
      e.e_def = model(0, def_data);
      e.e_a   = model(1, w);
      e.e_sat = model(2, w);
    end
    q.push_back(e);
    if (rst) begin
      #1;
      check("async_rst_def", out_def, 32'h0);
      check("async_rst_a",   out_a,   32'h0);
      check("async_rst_sat", out_sat, 32'h0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].edge_no <= edge_cnt) begin
        e = q.pop_front();
        check("sb_def", out_def, e.e_def);
        check("sb_a",   out_a,   e.e_a);
        check("sb_sat", out_sat, e.e_sat);
      end
    end
  end

  function automatic logic [31:0] pick_word();
    logic [31:0] pool [8] = '{32'hAAAA_0000, 32'h5555_0000, 32'h0800_4500, 32'h1234_5678,
                              32'hDEAD_BEEF, 32'h0800_45FF, 32'h1234_0000, 32'h0000_5678};
    logic [31:0] w = pool[$urandom_range(7)];
    case ($urandom_range(3))
      0: return $urandom();
      1: return w ^ (32'h1 << $urandom_range(31));
      default: return w;
    endcase
  endfunction

  initial begin : driver
    cfg_pat = '{256'h0, A_PAT, S_PAT};
    cfg_msk = '{{8{32'hFFFF_FFFF}}, A_MSK, S_MSK};
    cfg_en  = '{8'h00, A_EN, S_EN};
    for (int d = 0; d < 3; d++) begin prev0[d] = 0; cnt[d] = 0; end

    step(32'hDEAD_BEEF, 1'b1);
    step(32'hDEAD_BEEF, 1'b1);
    repeat (3) step(32'hDEAD_BEEF, 1'b0);

    step(32'h0, 1'b1);
    step(32'h0800_45AB, 1'b0);
    @(posedge clk); #1;
    check("slot2_direct", out_a, 32'h0001_0A04);
    #1;
    n_rst = 1'b0; data_in = 32'h0800_4600; def_data = 32'h0800_4600;
    q.push_back('{edge_cnt + 1, model(0, 32'h0800_4600), model(1, 32'h0800_4600), model(2, 32'h0800_4600)});

    step(32'h0, 1'b1);
    step(32'hAAAA_0000, 1'b0);
    step(32'h5555_0000, 1'b0);
    step(32'h5555_0000, 1'b0);
    step(32'hAAAA_0000, 1'b0);
    step(32'h1234_5678, 1'b0);
    step(32'hAAAA_0000, 1'b0);
    step(32'hAAAA_0000, 1'b1);
    step(32'h5555_0000, 1'b0);

    for (int n = 0; n < 1500; n++) step(pick_word(), ($urandom_range(199) == 0));

    step(32'h0, 1'b1);
    for (int n = 0; n < 65540; n++) step(pick_word(), 1'b0, 1'b1);
    @(posedge clk); #1;
    check("sat_count", {16'h0, out_sat[31:16]}, 32'h0000_FFFF);

    step(32'hAAAA_0000, 1'b1);
    step(32'h5555_0000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
